// File: rtl/alu_op_sequencer_if.sv
// Handshake, operand and ALU-result bundle between requester/ALU and alu_op_sequencer.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 19
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             use_acc;
  logic [WIDTH-1:0] alu_op;
  logic             ovf_flag;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] dr;
  logic [13:0]      ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf_out;
  logic             err;

  modport master (
    output start, opcode, operand_a, operand_b, use_acc, alu_op, ovf_flag,
    input  ac, dr, ctrl, busy, done, result, ovf_out, err
  );

  modport slave (
    input  start, opcode, operand_a, operand_b, use_acc, alu_op, ovf_flag,
    output ac, dr, ctrl, busy, done, result, ovf_out, err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Runs one ALU operation at a time: decodes opcode to one-hot CTRL, holds it for a
// settle time, captures the ALU result and reports it over START/BUSY/DONE.
module alu_op_sequencer #(
  parameter int WIDTH       = 19,
  parameter int MULDIV_WAIT = 3,
  parameter int SIMPLE_WAIT = 0
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int MAX_WAIT = (MULDIV_WAIT > SIMPLE_WAIT) ? MULDIV_WAIT : SIMPLE_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_LAST = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] ac_r;
  logic [WIDTH-1:0] dr_r;
  logic [13:0]      ctrl_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             ovf_r;
  logic             err_r;

  function automatic logic [13:0] onehot(input logic [3:0] op);
    logic [13:0] v;
    v = 14'd0;
    if (op <= OP_LAST) begin
      v = 14'd1 << op;
    end
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] settle_cycles(input logic [3:0] op);
    logic [CNT_W-1:0] c;
    if ((op == OP_MUL) || (op == OP_DIV)) begin
      c = CNT_W'(MULDIV_WAIT);
    end else begin
      c = CNT_W'(SIMPLE_WAIT);
    end
    return c;
  endfunction

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      ac_r     <= '0;
      dr_r     <= '0;
      ctrl_r   <= 14'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.opcode > OP_LAST) begin
              // Illegal opcode: report straight away, leave operands and RESULT alone.
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              ovf_r   <= 1'b0;
              state_r <= ST_FIN;
            end else begin
              ac_r    <= bus.use_acc ? result_r : bus.operand_a;
              dr_r    <= bus.operand_b;
              ctrl_r  <= onehot(bus.opcode);
              cnt_r   <= settle_cycles(bus.opcode);
              state_r <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            result_r <= bus.alu_op;
            ovf_r    <= bus.ovf_flag;
            ctrl_r   <= 14'd0;
            done_r   <= 1'b1;
            state_r  <= ST_FIN;
          end
        end
        ST_FIN: begin
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          ctrl_r  <= 14'd0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ac      = ac_r;
  assign bus.dr      = dr_r;
  assign bus.ctrl    = ctrl_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.ovf_out = ovf_r;
  assign bus.err     = err_r;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer with a behavioural 19-bit ALU model.
module tb_alu_op_sequencer;
  localparam int W = 19;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  alu_op_sequencer_if #(.WIDTH(W)) bus ();

  alu_op_sequencer #(.WIDTH(W), .MULDIV_WAIT(3), .SIMPLE_WAIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    int           lat;
    int           ctrl_cyc;
    logic [13:0]  oh;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] prev_res;
  logic [W:0]   alu_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    logic [2*W-1:0] wide;
    logic           ovf;
    wa   = {{W{1'b0}}, a};
    wb   = {{W{1'b0}}, b};
    wide = '0;
    ovf  = 1'b0;
    case (op)
      4'd0:  begin wide = wa + wb; ovf = wide[W]; end
      4'd1:  begin wide = wa - wb; ovf = (a < b); end
      4'd2:  begin wide = wa * wb; ovf = |wide[2*W-1:W]; end
      4'd3:  begin wide = (b == '0) ? '0 : wa / wb; ovf = (b == '0); end
      4'd4:  wide = wa & wb;
      4'd5:  wide = wa | wb;
      4'd6:  wide = wa ^ wb;
      4'd7:  wide = {{W{1'b0}}, ~a};
      4'd8:  begin wide = wa + 38'd1; ovf = wide[W]; end
      4'd9:  begin wide = wa - 38'd1; ovf = (a == '0); end
      4'd10: wide = {{W{1'b0}}, a ^ 19'h5A5A5};
      4'd11: wide = {{W{1'b0}}, a[W-2:0], a[W-1]};
      4'd12: wide = {{W{1'b0}}, a[0], a[W-1:1]};
      4'd13: wide = {{W{1'b0}}, a ^ b ^ 19'd1};
      default: wide = '0;
    endcase
    return {ovf, wide[W-1:0]};
  endfunction

  // Combinational ALU: only a single asserted CTRL line produces a result.
  always_comb begin
    alu_r = '0;
    for (int i = 0; i < 14; i++) begin
      if (bus.ctrl == (14'd1 << i)) begin
        alu_r = alu_ref(i[3:0], bus.ac, bus.dr);
      end
    end
    bus.alu_op   = alu_r[W-1:0];
    bus.ovf_flag = alu_r[W];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic acc, input bit inject);
    exp_t         e;
    exp_t         got_e;
    logic [W:0]   r;
    logic [W-1:0] ac_e;
    int           cnt;
    int           edges;
    int           ctrl_n;
    bit           got;
    cnt  = ((op == 4'd2) || (op == 4'd3)) ? 3 : 0;
    ac_e = acc ? prev_res : a;
    if (op <= 4'd13) begin
      r          = alu_ref(op, ac_e, b);
      e.res      = r[W-1:0];
      e.ovf      = r[W];
      e.err      = 1'b0;
      e.lat      = 2 + cnt;
      e.ctrl_cyc = 1 + cnt;
      e.oh       = 14'd1 << op;
      prev_res   = r[W-1:0];
    end else begin
      e.res      = prev_res;
      e.ovf      = 1'b0;
      e.err      = 1'b1;
      e.lat      = 1;
      e.ctrl_cyc = 0;
      e.oh       = 14'd0;
    end
    sb.push_back(e);

    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.use_acc   = acc;
    bus.start     = 1'b1;
    edges  = 0;
    ctrl_n = 0;
    got    = 1'b0;
    while (!got && edges < 30) begin
      tick();
      edges++;
      bus.start = 1'b0;
      if (inject && edges >= 2) begin
        bus.start  = 1'b1;
        bus.opcode = 4'd0;
      end
      if (bus.ctrl != 14'd0) begin
        ctrl_n++;
        check("ctrl_onehot", 32'(bus.ctrl), 32'(e.oh));
      end
      if (edges == 1 && e.err == 1'b0) begin
        check("ac_operand", 32'(bus.ac), 32'(ac_e));
        check("dr_operand", 32'(bus.dr), 32'(b));
      end
      check("busy_high", 32'(bus.busy), 32'd1);
      if (bus.done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    got_e = sb.pop_front();
    check("latency", 32'(edges), 32'(got_e.lat));
    check("ctrl_cycles", 32'(ctrl_n), 32'(got_e.ctrl_cyc));
    check("result", 32'(bus.result), 32'(got_e.res));
    check("ovf_out", 32'(bus.ovf_out), 32'(got_e.ovf));
    check("err", 32'(bus.err), 32'(got_e.err));
    check("ctrl_at_done", 32'(bus.ctrl), 32'd0);

    tick();
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("err_pulse", 32'(bus.err), 32'd0);
    check("busy_fin", 32'(bus.busy), 32'd0);
    if (inject) begin
      tick();
      check("ignored_busy", 32'(bus.busy), 32'd0);
      check("ignored_ctrl", 32'(bus.ctrl), 32'd0);
      check("ignored_done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    prev_res      = '0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.opcode    = 4'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.use_acc   = 1'b0;
    tick();
    tick();
    check("rst_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ac", 32'(bus.ac), 32'd0);
    check("rst_dr", 32'(bus.dr), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ovf", 32'(bus.ovf_out), 32'd0);
    rst = 1'b0;
    tick();

    // Plain ADD, then MUL with overflow, then an illegal opcode.
    run_op(4'd0, 19'd5, 19'd7, 1'b0, 1'b0);
    check("t1_result", 32'(bus.result), 32'd12);
    run_op(4'd2, 19'd262142, 19'd7, 1'b0, 1'b0);
    check("t2_result", 32'(bus.result), 32'd262130);
    run_op(4'd15, 19'd1, 19'd1, 1'b0, 1'b0);
    check("t3_result_kept", 32'(bus.result), 32'd262130);
    run_op(4'd14, 19'd9, 19'd9, 1'b1, 1'b0);

    // DIV with START re-asserted through EXEC and FIN.
    run_op(4'd3, 19'd100, 19'd7, 1'b0, 1'b1);
    check("t4_result", 32'(bus.result), 32'd14);

    // Chaining through USE_ACC.
    run_op(4'd0, 19'd3, 19'd4, 1'b0, 1'b0);
    run_op(4'd8, 19'd100, 19'd0, 1'b1, 1'b0);
    check("t5_result", 32'(bus.result), 32'd8);

    // A spread of remaining legal opcodes.
    for (int k = 4; k < 14; k++) begin
      if (k != 8) run_op(k[3:0], 19'h4A3C1, 19'h1F0F3, 1'b0, 1'b0);
    end
    run_op(4'd1, 19'd3, 19'd10, 1'b1, 1'b0);
    run_op(4'd9, 19'd0, 19'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    bus.opcode    = 4'd2;
    bus.operand_a = 19'd11;
    bus.operand_b = 19'd13;
    bus.use_acc   = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("t6_pre_ctrl", 32'(bus.ctrl), 32'h0004);
    #2;
    rst = 1'b1;
    #1;
    check("t6_ctrl", 32'(bus.ctrl), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_done", 32'(bus.done), 32'd0);
    check("t6_ac", 32'(bus.ac), 32'd0);
    check("t6_result", 32'(bus.result), 32'd0);
    prev_res = '0;
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle_done", 32'(bus.done), 32'd0);
    run_op(4'd0, 19'd10, 19'd20, 1'b1, 1'b0);
    check("t6_after", 32'(bus.result), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
